// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
// Used by multicycle_control_fsm and branch_cond_eval.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_AUIPC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_LOAD_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_WB,
        S_ILLEGAL,
        S_HALT
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic state_e decode_state(input logic [6:0] op);
        state_e s;
        case (op)
            OP_R:      s = S_EXEC_R;
            OP_IMM:    s = S_EXEC_I;
            OP_LOAD:   s = S_MEM_ADDR;
            OP_STORE:  s = S_MEM_ADDR;
            OP_BRANCH: s = S_BRANCH;
            OP_JAL:    s = S_JAL;
            OP_JALR:   s = S_JALR;
            OP_LUI:    s = S_LUI;
            OP_AUIPC:  s = S_AUIPC;
            default:   s = S_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_branch.sv
// Branch condition evaluator: funct3 plus ALU flags to taken.
// Reserved funct3 codes are never taken.
module branch_cond_eval
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = zero_i;
            F3_BNE:  taken_o = !zero_i;
            F3_BLT:  taken_o = lt_i;
            F3_BGE:  taken_o = !lt_i;
            F3_BLTU: taken_o = ltu_i;
            F3_BGEU: taken_o = !ltu_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM with req/ready memory handshake and timeout.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt and set illegal_instr.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       old_pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       addr_src,
    output logic       instr_done,
    output logic       bus_error,
    output logic       illegal_instr
);

    localparam int unsigned CW =
        (MEM_WAIT_LIMIT > 1) ? $clog2(MEM_WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST =
        CW'((MEM_WAIT_LIMIT == 0) ? 0 : MEM_WAIT_LIMIT - 1);
    localparam bit TMO_EN = (MEM_WAIT_LIMIT != 0);

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          store_q, store_d;
    logic          bus_err_q, bus_err_d;
    logic          br_taken;
    logic          stalled;

    branch_cond_eval u_br (
        .funct3_i (funct3),
        .zero_i   (zero),
        .lt_i     (lt),
        .ltu_i    (ltu),
        .taken_o  (br_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            store_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            store_q   <= store_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        bus_err_d    = bus_err_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        old_pc_write = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        result_src   = RES_ALUOUT;
        addr_src     = 1'b0;
        instr_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus_err_d = 1'b0;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    old_pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                store_d   = (opcode == OP_STORE);
                state_d   = decode_state(opcode);
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = store_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) state_d = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEMDATA;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = br_taken;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_JALR_WB;
            end
            S_JALR_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = S_HALT;
`else
                instr_done = 1'b1;
                state_d    = S_FETCH;
`endif
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A ready in the limit cycle completes normally: stalled needs !ready.
        stalled = mem_req && !mem_ready;
        if (TMO_EN && stalled && (wait_q == WAIT_LAST)) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (TMO_EN && stalled) begin
            wait_d = wait_q + CW'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    assign bus_error = bus_err_q;

`ifdef ILLEGAL_TRAP_EN
    logic ill_q, ill_d;

    always_comb begin
        ill_d = ill_q;
        if (state_q == S_IDLE) ill_d = 1'b0;
        if (state_q == S_ILLEGAL) ill_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign illegal_instr = ill_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: random program, memory responder,
// scoreboard of per-instruction retire latency and control at retirement.
module tb_multicycle_control_fsm;

    localparam int LIMIT = 4;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_write, pc_write, old_pc_write;
    logic       reg_write, addr_src, instr_done, bus_error, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [17:0] outs;

    multicycle_control_fsm #(.MEM_WAIT_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .zero          (zero),
        .lt            (lt),
        .ltu           (ltu),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .old_pc_write  (old_pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .addr_src      (addr_src),
        .instr_done    (instr_done),
        .bus_error     (bus_error),
        .illegal_instr (illegal_instr)
    );

    assign outs = {mem_req, mem_we, ir_write, pc_write, old_pc_write,
                   reg_write, alu_src_a, alu_src_b, alu_op, result_src,
                   addr_src, instr_done, bus_error, illegal_instr};

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       z;
        logic       l;
        logic       lu;
        int         fw;
        int         dw;
    } instr_t;

    typedef struct {
        int         kind;
        int         lat;
        logic       pcw;
        logic       rw;
        logic       we;
        logic [1:0] rs;
        bit         chk_rs;
    } exp_t;

    instr_t pq[$];
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3,
                                  input logic z, input logic l,
                                  input logic lu, input int fw, input int dw);
        instr_t t;
        t.opc = op; t.f3 = f3; t.z = z; t.l = l; t.lu = lu;
        t.fw = fw; t.dw = dw;
        return t;
    endfunction

    function automatic logic taken(input instr_t t);
        case (t.f3)
            3'd0: return t.z;
            3'd1: return !t.z;
            3'd4: return t.l;
            3'd5: return !t.l;
            3'd6: return t.lu;
            3'd7: return !t.lu;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: cycles from first FETCH cycle to retirement, plus what
    // the retiring cycle must drive.
    function automatic exp_t model(input instr_t t);
        exp_t e;
        int   base;
        e.kind = 0; e.pcw = 0; e.rw = 0; e.we = 0; e.rs = 0; e.chk_rs = 0;
        case (t.opc)
            7'h33, 7'h13, 7'h37, 7'h17: begin
                base = 4; e.rw = 1; e.rs = 2'd0; e.chk_rs = 1;
            end
            7'h03: begin
                base = 5 + t.dw; e.rw = 1; e.rs = 2'd1; e.chk_rs = 1;
            end
            7'h23: begin
                base = 4 + t.dw; e.we = 1;
            end
            7'h63: begin
                base = 3; e.pcw = taken(t); e.rs = 2'd0; e.chk_rs = 1;
            end
            7'h6F: begin
                base = 3; e.rw = 1; e.pcw = 1; e.rs = 2'd2; e.chk_rs = 1;
            end
            7'h67: begin
                base = 4; e.rw = 1; e.pcw = 1; e.rs = 2'd2; e.chk_rs = 1;
            end
            default: begin
                if (TRAP) begin
                    e.kind = 2; base = 4;
                end else begin
                    base = 3;
                end
            end
        endcase
        e.lat = base + t.fw;
        return e;
    endfunction

    task automatic issue(input instr_t t);
        pq.push_back(t);
        sb.push_back(model(t));
    endtask

    task automatic issue_timeout();
        exp_t e;
        pq.push_back(mk(7'h33, 3'd0, 0, 0, 0, 1000000, 0));
        e.kind = 1; e.lat = LIMIT + 1;
        e.pcw = 0; e.rw = 0; e.we = 0; e.rs = 0; e.chk_rs = 0;
        sb.push_back(e);
    endtask

    task automatic set_reset(input logic v);
        @(posedge clk);
        #2;
        reset = v;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Memory responder: fetch when addr_src=0, data access otherwise.
    instr_t cur;
    int     wcnt = 0;
    always begin
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        if (reset) begin
            wcnt = 0;
        end else if (mem_req && !addr_src) begin
            if (pq.size() != 0) begin
                if (wcnt >= pq[0].fw) begin
                    cur = pq.pop_front();
                    mem_ready = 1'b1;
                    opcode = cur.opc;
                    funct3 = cur.f3;
                    zero = cur.z;
                    lt = cur.l;
                    ltu = cur.lu;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end else if (mem_req) begin
            if (wcnt >= cur.dw) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on retire / error / trap events.
    bit   active = 0;
    int   lat = 0;
    int   ev;
    logic prev_req = 0, prev_rdy = 0, prev_we = 0, prev_as = 0;
    logic prev_be = 0, prev_il = 0;
    exp_t e;
    always @(negedge clk) begin
        if (reset) begin
            active = 0; lat = 0; prev_req = 0; prev_rdy = 0;
            prev_be = 0; prev_il = 0;
        end else begin
            if (prev_req && !prev_rdy && !bus_error)
                chk("req_hold", 32'({mem_req, mem_we, addr_src}),
                    32'({1'b1, prev_we, prev_as}));
            if (ir_write)
                chk("fetch_ctl", 32'({mem_req, mem_ready, addr_src,
                    old_pc_write, pc_write, alu_src_a, alu_src_b,
                    result_src}), 32'({5'b11011, 2'd0, 2'd2, 2'd2}));
            if (reg_write) chk("rw_at_retire", 32'(instr_done), 32'd1);
            if (pc_write && !ir_write)
                chk("pcw_at_retire", 32'(instr_done), 32'd1);
            if (!active && mem_req) active = 1;
            if (active) lat++;
            ev = -1;
            if (instr_done) ev = 0;
            else if (bus_error && !prev_be) ev = 1;
            else if (illegal_instr && !prev_il) ev = 2;
            if (ev >= 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'(ev), 32'hFFFFFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 32'(ev), 32'(e.kind));
                    chk("latency", 32'(lat), 32'(e.lat));
                    if (ev == 0) begin
                        chk("pc_write", 32'(pc_write), 32'(e.pcw));
                        chk("reg_write", 32'(reg_write), 32'(e.rw));
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        if (e.chk_rs)
                            chk("result_src", 32'(result_src), 32'(e.rs));
                    end
                end
                lat = 0;
            end
            prev_req = mem_req; prev_rdy = mem_ready;
            prev_we = mem_we; prev_as = addr_src;
            prev_be = bus_error; prev_il = illegal_instr;
        end
    end

    logic [6:0] ops [10];

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", 32'(outs), 32'd0);
        end

        issue(mk(7'h33, 3'd0, 0, 0, 0, 0, 0));
        issue(mk(7'h03, 3'd2, 0, 0, 0, 2, 2));
        issue(mk(7'h63, 3'd0, 1, 0, 0, 0, 0));
        issue(mk(7'h63, 3'd0, 0, 0, 0, 0, 0));
        issue(mk(7'h23, 3'd2, 0, 0, 0, 0, 0));
        issue(mk(7'h67, 3'd0, 0, 0, 0, 0, 0));
        issue(mk(7'h13, 3'd0, 0, 0, 0, LIMIT - 1, 0));
        issue(mk(7'h23, 3'd2, 0, 0, 0, 0, LIMIT - 1));
        for (int i = 0; i < 40; i++) begin
            issue(mk(ops[$urandom_range(0, TRAP ? 8 : 9)],
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, LIMIT - 1),
                     $urandom_range(0, LIMIT - 1)));
        end
        if (!TRAP) issue(mk(7'h7F, 3'd7, 0, 0, 0, 0, 0));
        issue_timeout();

        set_reset(1'b0);
        @(negedge clk);
        chk("idle_outs", 32'(outs), 32'd0);
        @(negedge clk);
        chk("first_fetch_req", 32'(mem_req), 32'd1);
        drain("program_drain");
        repeat (8) begin
            @(negedge clk);
            chk("halt_hold", 32'(outs), 32'd2);
        end

        set_reset(1'b1);
        pq.delete();
        @(negedge clk);
        @(negedge clk);
        chk("reset_clears", 32'(outs), 32'd0);

`ifdef ILLEGAL_TRAP_EN
        issue(mk(7'h7F, 3'd7, 0, 0, 0, 1, 0));
        set_reset(1'b0);
        drain("trap_drain");
        repeat (4) begin
            @(negedge clk);
            chk("trap_halt", 32'(outs), 32'd1);
        end
        set_reset(1'b1);
        pq.delete();
        @(negedge clk);
        @(negedge clk);
        chk("trap_reset_clears", 32'(outs), 32'd0);
`endif

        pq.push_back(mk(7'h33, 3'd0, 0, 0, 0, 3, 0));
        set_reset(1'b0);
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        chk("abort_req_seen", 32'(mem_req), 32'd1);
        set_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_req_drop", 32'(mem_req), 32'd0);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
